// File: rtl/ifft_frame_ctrl.sv
// Frame controller around a 64-point pipelined IFFT: gates the IFFT clock enable,
// zero-pads a short final symbol, flushes the pipeline and marks symbol boundaries.
`timescale 1ns/1ps
module ifft_frame_ctrl #(
  parameter int LGN       = 6,
  parameter int DW        = 32,
  parameter int SYMW      = 10,
  parameter int FLUSH_MAX = 512
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  input  logic          i_in_last,
  output logic          o_fft_reset,
  output logic          o_fft_ce,
  output logic [DW-1:0] o_fft_sample,
  input  logic [DW-1:0] i_fft_result,
  input  logic          i_fft_sync,
  input  logic          i_out_ready,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_first,
  output logic          o_out_last,
  output logic          o_done,
  output logic          o_err,
  output logic [2:0]    o_dbg_state
);

  // Handshakes: an upstream sample moves when i_in_valid & o_in_ready; the IFFT
  // advances only on o_fft_ce; o_out_valid is a one-cycle strobe that downstream
  // pre-approved with i_out_ready on the previous cycle, so it is never stalled.

  localparam int FW = $clog2(FLUSH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAD   = 3'd2,
    S_FLUSH = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LGN-1:0]  in_idx_q, in_idx_d;
  logic [LGN-1:0]  out_idx_q, out_idx_d;
  logic [SYMW-1:0] sym_in_q, sym_in_d;
  logic [SYMW-1:0] sym_out_q, sym_out_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            primed_q, primed_d;
  logic            ce_d1_q, ce_d1_d;
  logic            err_q, err_d;
  logic            fft_rst_q, fft_rst_d;

  logic            accept;
  logic            pad_ce;
  logic            flush_ce;
  logic            in_at_end;
  logic            out_wrap;
  logic            final_out;
  logic [FW-1:0]   flush_inc;
  logic            flush_timeout;
  logic            sync_misaligned;

  assign accept          = i_in_valid & o_in_ready;
  assign pad_ce          = (state_q == S_PAD) & o_fft_ce;
  assign flush_ce        = (state_q == S_FLUSH) & o_fft_ce;
  assign in_at_end       = (in_idx_q == {LGN{1'b1}});
  assign o_out_valid     = ce_d1_q & (primed_q | i_fft_sync) & (sym_out_q != sym_in_q);
  assign out_wrap        = o_out_valid & (out_idx_q == {LGN{1'b1}});
  // Only in FLUSH has every symbol of the packet entered, so sym_in is final.
  assign final_out       = out_wrap & (state_q == S_FLUSH) & ((sym_out_q + SYMW'(1)) == sym_in_q);
  assign flush_inc       = flush_cnt_q + FW'(1);
  assign flush_timeout   = flush_ce & (flush_inc == FW'(FLUSH_MAX)) & ~final_out;
  assign sync_misaligned = o_out_valid & i_fft_sync & (out_idx_q != '0);

  assign o_out_data  = i_fft_result;
  assign o_out_first = o_out_valid & i_fft_sync;
  assign o_out_last  = final_out;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          if (i_in_last) state_d = in_at_end ? S_FLUSH : S_PAD;
          else           state_d = S_RUN;
        end
      end
      S_PAD:   if (pad_ce && in_at_end) state_d = S_FLUSH;
      S_FLUSH: if (final_out || flush_timeout) state_d = S_CLEAR;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The IFFT is held off while its own reset is asserted.
  always_comb begin
    o_in_ready   = 1'b0;
    o_fft_ce     = 1'b0;
    o_fft_sample = '0;
    o_done       = (state_q == S_CLEAR);
    o_fft_reset  = fft_rst_q | (state_q == S_CLEAR);
    if (!fft_rst_q) begin
      case (state_q)
        S_IDLE, S_RUN: begin
          o_in_ready   = i_out_ready;
          o_fft_ce     = i_in_valid & i_out_ready;
          o_fft_sample = i_in_data;
        end
        S_PAD, S_FLUSH: o_fft_ce = i_out_ready;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    sym_in_d    = sym_in_q;
    sym_out_d   = sym_out_q;
    flush_cnt_d = flush_cnt_q;
    primed_d    = primed_q;
    ce_d1_d     = o_fft_ce;
    err_d       = err_q | flush_timeout | sync_misaligned;
    fft_rst_d   = 1'b0;

    if (accept || pad_ce) begin
      in_idx_d = in_idx_q + LGN'(1);
      if (in_at_end) sym_in_d = sym_in_q + SYMW'(1);
    end
    if (flush_ce) flush_cnt_d = flush_inc;
    if (o_out_valid) begin
      primed_d  = 1'b1;
      out_idx_d = out_idx_q + LGN'(1);
      if (out_wrap) sym_out_d = sym_out_q + SYMW'(1);
    end

    if (state_q == S_CLEAR) begin
      in_idx_d    = '0;
      out_idx_d   = '0;
      sym_in_d    = '0;
      sym_out_d   = '0;
      flush_cnt_d = '0;
      primed_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      sym_in_q    <= '0;
      sym_out_q   <= '0;
      flush_cnt_q <= '0;
      primed_q    <= 1'b0;
      ce_d1_q     <= 1'b0;
      err_q       <= 1'b0;
      fft_rst_q   <= 1'b1;
    end else begin
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      sym_in_q    <= sym_in_d;
      sym_out_q   <= sym_out_d;
      flush_cnt_q <= flush_cnt_d;
      primed_q    <= primed_d;
      ce_d1_q     <= ce_d1_d;
      err_q       <= err_d;
      fft_rst_q   <= fft_rst_d;
    end
  end

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Bench for ifft_frame_ctrl: a ce-gated delay-line IFFT stand-in, randomized packets,
// and an expected-output queue filled from a padded-packet reference model.
`timescale 1ns/1ps
module tb_ifft_frame_ctrl;
  localparam int DW        = 32;
  localparam int LGN       = 6;
  localparam int SYMW      = 10;
  localparam int FLUSH_MAX = 512;
  localparam int N         = 64;
  localparam int LAT       = 70;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;

  logic          clk;
  logic          i_reset;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_in_data;
  logic          i_in_last;
  logic          o_fft_reset;
  logic          o_fft_ce;
  logic [DW-1:0] o_fft_sample;
  logic [DW-1:0] i_fft_result;
  logic          i_fft_sync;
  logic          i_out_ready;
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic          o_out_first;
  logic          o_out_last;
  logic          o_done;
  logic          o_err;
  logic [2:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];
  int done_cnt, out_cnt, pad_cnt, flush_ce_cnt;
  int rdy_mode;
  bit kill_sync;
  bit prev_done;

  ifft_frame_ctrl #(.LGN(LGN), .DW(DW), .SYMW(SYMW), .FLUSH_MAX(FLUSH_MAX)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data), .i_in_last(i_in_last),
    .o_fft_reset(o_fft_reset), .o_fft_ce(o_fft_ce), .o_fft_sample(o_fft_sample),
    .i_fft_result(i_fft_result), .i_fft_sync(i_fft_sync), .i_out_ready(i_out_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_first(o_out_first),
    .o_out_last(o_out_last), .o_done(o_done), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IFFT stand-in: LAT-deep ce-gated delay line, sync tags every 64th pushed sample
  logic [DW:0] pipe [LAT];
  logic        fft_sync_raw;
  int          stub_cnt;
  always @(posedge clk) begin
    if (o_fft_reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      i_fft_result <= '0;
      fft_sync_raw <= 1'b0;
      stub_cnt     <= 0;
    end else if (o_fft_ce) begin
      i_fft_result <= pipe[LAT-1][DW-1:0];
      fft_sync_raw <= pipe[LAT-1][DW];
      for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0]  <= {((stub_cnt % N) == 0), o_fft_sample};
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign i_fft_sync = fft_sync_raw & ~kill_sync;

  // downstream ready pattern
  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       i_out_ready = ~i_out_ready;
        2:       i_out_ready = 1'($urandom_range(0, 1));
        default: i_out_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [DW+1:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (i_reset) begin
        prev_done = 1'b0;
      end else begin
        if (o_out_valid) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 64'(o_out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_sample", 64'({o_out_data, o_out_first, o_out_last}), 64'(e));
          end
        end
        if (o_done) begin
          done_cnt++;
          chk("reset_in_clear", 64'(o_fft_reset), 64'd1);
        end
        if (prev_done) chk("reset_pulse_width", 64'(o_fft_reset), 64'd0);
        prev_done = o_done;
        if (!i_out_ready) chk("ce_while_not_ready", 64'(o_fft_ce), 64'd0);
        if (o_dbg_state >= ST_PAD) chk("in_ready_blocked", 64'(o_in_ready), 64'd0);
        if (o_fft_ce && o_dbg_state == ST_PAD) begin
          pad_cnt++;
          chk("pad_zero", 64'(o_fft_sample), 64'd0);
        end
        if (o_fft_ce && o_dbg_state == ST_FLUSH) flush_ce_cnt++;
      end
    end
  end

  task automatic reset_counts();
    done_cnt = 0; out_cnt = 0; pad_cnt = 0; flush_ce_cnt = 0;
  endtask

  // driver: reference model pushes the zero-padded packet, then samples are offered
  task automatic send_packet(input int n, input bit gaps, input bit push_exp);
    logic [DW-1:0] d[$];
    logic [DW-1:0] v;
    int total, k, guard;
    bit acc;
    for (int j = 0; j < n; j++) d.push_back($urandom);
    total = ((n + N - 1) / N) * N;
    if (push_exp)
      for (int j = 0; j < total; j++) begin
        v = (j < n) ? d[j] : '0;
        exp_q.push_back({v, ((j % N) == 0), (j == total - 1)});
      end
    k = 0; guard = 0;
    while (k < n && guard < 20000) begin
      @(negedge clk);
      i_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_in_data  = d[k];
      i_in_last  = (k == n - 1);
      #1;
      acc = i_in_valid && o_in_ready;
      @(posedge clk);
      if (acc) k++;
      guard++;
    end
    chk("send_complete", 64'(k), 64'(n));
    @(negedge clk);
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    chk("done_count", 64'(done_cnt), 64'(target));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 i_reset = 1'b1;
    #1;
    chk("rst_fft_reset", 64'(o_fft_reset), 64'd1);
    chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    chk("rst_err", 64'(o_err), 64'd0);
    exp_q.delete();
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    reset_counts();
  endtask

  initial begin
    int cyc;
    i_reset = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_in_last = 1'b0;
    rdy_mode = 0; kill_sync = 1'b0;
    reset_counts();
    repeat (2) @(negedge clk);
    #2;
    chk("init_fft_reset", 64'(o_fft_reset), 64'd1);
    chk("init_in_ready", 64'(o_in_ready), 64'd0);
    chk("init_fft_ce", 64'(o_fft_ce), 64'd0);
    chk("init_out_valid", 64'(o_out_valid), 64'd0);
    chk("init_done", 64'(o_done), 64'd0);
    chk("init_err", 64'(o_err), 64'd0);
    chk("init_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1 chk("fft_reset_release", 64'(o_fft_reset), 64'd0);

    // one full symbol
    reset_counts();
    send_packet(64, 1'b0, 1'b1);
    wait_done(1);
    chk("t1_outputs", 64'(out_cnt), 64'd64);

    // three symbols
    reset_counts();
    send_packet(192, 1'b0, 1'b1);
    wait_done(1);
    chk("t2_outputs", 64'(out_cnt), 64'd192);

    // short packet padded with zeros
    reset_counts();
    send_packet(40, 1'b0, 1'b1);
    wait_done(1);
    chk("t3_pads", 64'(pad_cnt), 64'd24);
    chk("t3_outputs", 64'(out_cnt), 64'd64);

    // first sample is also last
    reset_counts();
    send_packet(1, 1'b0, 1'b1);
    wait_done(1);
    chk("t3b_pads", 64'(pad_cnt), 64'd63);

    // downstream ready toggling, upstream gaps
    reset_counts();
    rdy_mode = 1;
    send_packet(128, 1'b1, 1'b1);
    wait_done(1);
    chk("t4_outputs", 64'(out_cnt), 64'd128);
    rdy_mode = 0;

    // reset while flushing, then a clean packet
    reset_counts();
    send_packet(64, 1'b0, 1'b1);
    cyc = 0;
    while (o_dbg_state != ST_FLUSH && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    chk("t5_reached_flush", 64'(o_dbg_state), 64'(ST_FLUSH));
    repeat (20) @(posedge clk);
    pulse_reset();
    send_packet(64, 1'b0, 1'b1);
    wait_done(1);
    chk("t5_outputs", 64'(out_cnt), 64'd64);

    // back-to-back 1- and 2-symbol packets
    reset_counts();
    send_packet(64, 1'b0, 1'b1);
    send_packet(128, 1'b0, 1'b1);
    wait_done(2);
    chk("t6_outputs", 64'(out_cnt), 64'd192);
    chk("t6_no_err", 64'(o_err), 64'd0);

    // sync missing: no output, flush times out
    reset_counts();
    kill_sync = 1'b1;
    send_packet(64, 1'b0, 1'b0);
    wait_done(1);
    chk("t7_err", 64'(o_err), 64'd1);
    chk("t7_flush_ce", 64'(flush_ce_cnt), 64'(FLUSH_MAX));
    chk("t7_outputs", 64'(out_cnt), 64'd0);
    kill_sync = 1'b0;
    repeat (3) @(posedge clk);
    chk("t7_err_sticky", 64'(o_err), 64'd1);
    pulse_reset();
    #2 chk("t7_err_cleared", 64'(o_err), 64'd0);

    // randomized back-to-back packets with random ready and gaps
    reset_counts();
    rdy_mode = 2;
    for (int p = 0; p < 3; p++) send_packet($urandom_range(1, 200), 1'b1, 1'b1);
    wait_done(3);
    rdy_mode = 0;
    chk("t8_no_err", 64'(o_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
